multicycle_control: RTL and testbench

- Moore control FSM for the 32-bit multicycle RV32I subset datapath: lw, sw, add, sub, and, or, addi, andi, ori, beq.
- Sits directly upstream of the datapath. Consumes the IR fields and the ALU zero flag. Drives every mux select, write strobe and the 4-bit ALU control code.
- One instruction runs at a time: 3–5 cycles each. Adds a sticky illegal-instruction flag and a retire pulse for bench/debug.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/alu_decoder.sv | 50 +++++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset control FSM.
// Holds state encodings, opcodes, ALU codes and the packed control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Operation class seen by the ALU decoder; CLS_NONE marks an unknown opcode.
  typedef enum logic [2:0] {
    CLS_FETCH,
    CLS_MEM,
    CLS_BRANCH,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_NONE
  } alu_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic [3:0] alu_control;
    logic       illegal_inst;
    logic       instr_done;
  } ctrl_t;

  function automatic alu_class_t opcode_class(input logic [6:0] op);
    alu_class_t cls;
    case (op)
      OP_LOAD, OP_STORE: cls = CLS_MEM;
      OP_RTYPE:          cls = CLS_RTYPE;
      OP_ITYPE:          cls = CLS_ITYPE;
      OP_BRANCH:         cls = CLS_BRANCH;
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller is the master: it reads IR fields and zero, drives all strobes.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_source;
  logic [3:0] alu_control;
  logic       illegal_inst;
  logic       instr_done;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, pc_source, alu_control, illegal_inst, instr_done
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, pc_source, alu_control, illegal_inst, instr_done
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU-control decoder; also reports whether funct3/funct7_5 form
// a supported encoding for the given operation class.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_class_t cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (cls)
      CLS_FETCH: begin
        legal = 1'b1;
      end
      CLS_MEM: begin
        // Only word loads/stores are supported.
        legal = (funct3 == 3'b010);
      end
      CLS_BRANCH: begin
        alu_control = ALU_SUB;
        legal       = (funct3 == 3'b000);
      end
      CLS_RTYPE: begin
        case ({funct7_5, funct3})
          4'b0000: begin alu_control = ALU_ADD; legal = 1'b1; end
          4'b1000: begin alu_control = ALU_SUB; legal = 1'b1; end
          4'b0111: begin alu_control = ALU_AND; legal = 1'b1; end
          4'b0110: begin alu_control = ALU_OR;  legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      CLS_ITYPE: begin
        // funct7_5 is an immediate bit here and does not affect the operation.
        case (funct3)
          3'b000:  begin alu_control = ALU_ADD; legal = 1'b1; end
          3'b111:  begin alu_control = ALU_AND; legal = 1'b1; end
          3'b110:  begin alu_control = ALU_OR;  legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I-subset datapath (lw/sw/R/I/beq).
// Drives all datapath strobes, a sticky illegal flag and a per-instruction retire pulse.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  alu_class_t dec_cls;
  logic [3:0] dec_alu;
  logic       dec_legal;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // In DECODE the decoder classifies the raw opcode for the legality check;
  // elsewhere it is driven by the current state to produce the ALU code.
  always_comb begin
    dec_cls = CLS_FETCH;
    unique case (state_q)
      S_DECODE:   dec_cls = opcode_class(bus.opcode);
      S_MEM_ADDR: dec_cls = CLS_MEM;
      S_BRANCH:   dec_cls = CLS_BRANCH;
      S_EXEC_R:   dec_cls = CLS_RTYPE;
      S_EXEC_I:   dec_cls = CLS_ITYPE;
      default:    dec_cls = CLS_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls         (dec_cls),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7_5),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          // PC already advanced here, so returning to FETCH skips the instruction.
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end else begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
            OP_RTYPE:          state_d = S_EXEC_R;
            OP_ITYPE:          state_d = S_EXEC_I;
            OP_BRANCH:         state_d = S_BRANCH;
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LOAD) begin
          state_d = S_MEM_READ;
        end else if (bus.opcode == OP_STORE) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_READ:  state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_control = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        ctrl.pc_write    = 1'b1;
        ctrl.pc_source   = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = dec_legal ? dec_alu : ALU_ADD;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = dec_legal ? dec_alu : ALU_ADD;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_source   = 1'b1;
        ctrl.pc_write    = bus.zero;
        ctrl.instr_done  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    ctrl.illegal_inst = illegal_q;
    // Gate on reset itself so outputs drop in the same cycle reset rises.
    if (reset) begin
      ctrl = '0;
    end
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.i_or_d       = ctrl.i_or_d;
  assign bus.mem_read     = ctrl.mem_read;
  assign bus.mem_write    = ctrl.mem_write;
  assign bus.ir_write     = ctrl.ir_write;
  assign bus.mem_to_reg   = ctrl.mem_to_reg;
  assign bus.reg_write    = ctrl.reg_write;
  assign bus.alu_src_a    = ctrl.alu_src_a;
  assign bus.alu_src_b    = ctrl.alu_src_b;
  assign bus.pc_source    = ctrl.pc_source;
  assign bus.alu_control  = ctrl.alu_control;
  assign bus.illegal_inst = ctrl.illegal_inst;
  assign bus.instr_done   = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the expected control
// word for each cycle, a negedge monitor pops and compares it against the DUT.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int K_LW  = 0;
  localparam int K_SW  = 1;
  localparam int K_R   = 2;
  localparam int K_I   = 3;
  localparam int K_BEQ = 4;
  localparam int K_ILL = 5;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         kind;
    logic [3:0] alu;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_control_if bus ();

  multicycle_control #(.RESET_STATE(S_FETCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          done_exp = 0;
  logic        il = 1'b0;
  logic        final_check = 1'b0;

  // Field order: pc_write,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_write,
  // alu_src_a,alu_src_b[1:0],pc_source,alu_control[3:0],illegal_inst,instr_done
  function automatic logic [16:0] vec(input logic pw, iod, mr, mw, irw, m2r, rw, sa,
                                      input logic [1:0] sb, input logic ps,
                                      input logic [3:0] ac, input logic ill, dn);
    return {pw, iod, mr, mw, irw, m2r, rw, sa, sb, ps, ac, ill, dn};
  endfunction

  function automatic logic [16:0] v_fetch(input logic ill);
    return vec(0, 0, 1, 0, 1, 0, 0, 0, 2'b01, 0, 4'b0010, ill, 0);
  endfunction
  function automatic logic [16:0] v_decode(input logic ill);
    return vec(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 4'b0010, ill, 0);
  endfunction
  function automatic logic [16:0] v_memaddr(input logic ill);
    return vec(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 4'b0010, ill, 0);
  endfunction
  function automatic logic [16:0] v_memread(input logic ill);
    return vec(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, ill, 0);
  endfunction
  function automatic logic [16:0] v_memwb(input logic ill);
    return vec(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 4'b0000, ill, 1);
  endfunction
  function automatic logic [16:0] v_memwrite(input logic ill);
    return vec(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 4'b0000, ill, 1);
  endfunction
  function automatic logic [16:0] v_exec(input logic ill, input logic [1:0] sb,
                                         input logic [3:0] ac);
    return vec(0, 0, 0, 0, 0, 0, 0, 1, sb, 0, ac, ill, 0);
  endfunction
  function automatic logic [16:0] v_aluwb(input logic ill);
    return vec(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4'b0000, ill, 1);
  endfunction
  function automatic logic [16:0] v_branch(input logic ill, input logic z);
    return vec(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 4'b0110, ill, 1);
  endfunction

  always @(negedge clk) begin
    logic [16:0] got;
    logic [16:0] e;
    string       nm;
    got = {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
           bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
           bus.alu_control, bus.illegal_inst, bus.instr_done};
    if (!reset && bus.instr_done) done_seen++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b want %b", nm, got, e);
      end
    end
    if (final_check) begin
      checks++;
      if (done_seen != done_exp) begin
        errors++;
        $display("FAIL instr_done_count: got %0d want %0d", done_seen, done_exp);
      end
    end
  end

  task automatic push(input string nm, input logic [16:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input vec_t t);
    bus.opcode   = t.op;
    bus.funct3   = t.f3;
    bus.funct7_5 = t.f7;
    bus.zero     = t.z;
  endtask

  task automatic run(input vec_t t);
    set_inputs(t);
    push({t.nm, ":fetch"}, v_fetch(il));
    step();
    push({t.nm, ":decode"}, v_decode(il));
    step();
    case (t.kind)
      K_LW: begin
        push({t.nm, ":mem_addr"}, v_memaddr(il));  step();
        push({t.nm, ":mem_read"}, v_memread(il));  step();
        push({t.nm, ":mem_wb"}, v_memwb(il));      step();
        done_exp++;
      end
      K_SW: begin
        push({t.nm, ":mem_addr"}, v_memaddr(il));   step();
        push({t.nm, ":mem_write"}, v_memwrite(il)); step();
        done_exp++;
      end
      K_R: begin
        push({t.nm, ":exec_r"}, v_exec(il, 2'b00, t.alu)); step();
        push({t.nm, ":alu_wb"}, v_aluwb(il));              step();
        done_exp++;
      end
      K_I: begin
        push({t.nm, ":exec_i"}, v_exec(il, 2'b10, t.alu)); step();
        push({t.nm, ":alu_wb"}, v_aluwb(il));              step();
        done_exp++;
      end
      K_BEQ: begin
        push({t.nm, ":branch"}, v_branch(il, t.z)); step();
        done_exp++;
      end
      default: il = 1'b1;
    endcase
  endtask

  initial begin
    vec_t legal_tbl[$];
    vec_t ill_tbl[$];
    vec_t post_tbl[$];
    vec_t t;

    legal_tbl.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, K_R,   4'b0010, "add"});
    legal_tbl.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, K_R,   4'b0110, "sub"});
    legal_tbl.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, K_R,   4'b0000, "and"});
    legal_tbl.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, K_R,   4'b0001, "or"});
    legal_tbl.push_back('{7'b0010011, 3'b000, 1'b0, 1'b0, K_I,   4'b0010, "addi"});
    legal_tbl.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, K_I,   4'b0010, "addi_negimm"});
    legal_tbl.push_back('{7'b0010011, 3'b111, 1'b0, 1'b0, K_I,   4'b0000, "andi"});
    legal_tbl.push_back('{7'b0010011, 3'b110, 1'b0, 1'b0, K_I,   4'b0001, "ori"});
    legal_tbl.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, K_LW,  4'b0010, "lw"});
    legal_tbl.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, K_SW,  4'b0010, "sw"});
    legal_tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, K_BEQ, 4'b0110, "beq_taken"});
    legal_tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, K_BEQ, 4'b0110, "beq_not_taken"});

    ill_tbl.push_back('{7'b1111111, 3'b000, 1'b0, 1'b0, K_ILL, 4'b0000, "ill_opcode"});
    ill_tbl.push_back('{7'b0110011, 3'b001, 1'b0, 1'b0, K_ILL, 4'b0000, "ill_sll"});
    ill_tbl.push_back('{7'b0000011, 3'b000, 1'b0, 1'b0, K_ILL, 4'b0000, "ill_lb"});
    ill_tbl.push_back('{7'b1100011, 3'b001, 1'b0, 1'b1, K_ILL, 4'b0000, "ill_bne"});
    ill_tbl.push_back('{7'b0110011, 3'b111, 1'b1, 1'b0, K_ILL, 4'b0000, "ill_r_f7and"});

    post_tbl.push_back('{7'b0010011, 3'b110, 1'b0, 1'b0, K_I,  4'b0001, "ori_sticky"});
    post_tbl.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, K_LW, 4'b0010, "lw_sticky"});

    bus.opcode   = '0;
    bus.funct3   = '0;
    bus.funct7_5 = 1'b0;
    bus.zero     = 1'b0;

    // Power-on reset: all outputs zero while held.
    step();
    push("reset_hold0", '0); step();
    push("reset_hold1", '0); step();
    reset = 1'b0;
    il    = 1'b0;

    foreach (legal_tbl[i]) run(legal_tbl[i]);

    // Reset held during EXEC_R: outputs zero, FETCH right after release.
    t = legal_tbl[1];
    set_inputs(t);
    push("rst_mid:fetch", v_fetch(il));   step();
    push("rst_mid:decode", v_decode(il)); step();
    push("rst_mid:exec_r", v_exec(il, 2'b00, 4'b0110));
    #6 reset = 1'b1;
    step();
    push("rst_mid:held0", '0); step();
    push("rst_mid:held1", '0); step();
    reset = 1'b0;
    il    = 1'b0;
    push("rst_mid:post_fetch", v_fetch(il)); step();
    push("rst_mid:post_decode", v_decode(il)); step();
    push("rst_mid:post_exec_r", v_exec(il, 2'b00, 4'b0110)); step();
    push("rst_mid:post_alu_wb", v_aluwb(il)); step();
    done_exp++;

    // Short reset pulse between edges: state must already be FETCH at the next edge.
    t = legal_tbl[2];
    set_inputs(t);
    push("rst_pulse:fetch", v_fetch(il));   step();
    push("rst_pulse:decode", v_decode(il)); step();
    push("rst_pulse:exec_r", v_exec(il, 2'b00, 4'b0000));
    #6 reset = 1'b1;
    #1 reset = 1'b0;
    step();
    push("rst_pulse:decode_again", v_decode(il)); step();
    push("rst_pulse:exec_r_again", v_exec(il, 2'b00, 4'b0000)); step();
    push("rst_pulse:alu_wb", v_aluwb(il)); step();
    done_exp++;

    foreach (ill_tbl[i]) run(ill_tbl[i]);
    foreach (post_tbl[i]) run(post_tbl[i]);

    // Only reset clears the sticky flag.
    reset = 1'b1;
    push("final_reset", '0); step();
    reset = 1'b0;
    il    = 1'b0;
    push("final_reset:fetch", v_fetch(il));   step();
    push("final_reset:decode", v_decode(il)); step();

    final_check = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
